// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data BRAM between the CPU load/store port and the
// debug/loader port. The CPU wins by default, a wait counter guarantees the
// debug port a slot, and dbg_lock gives the debug port exclusive ownership.
// Read data returns one cycle after the grant and goes only to the requester
// that issued the read.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_core,
  input  logic              async_reset_n,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic [3:0]        dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              addr_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  owner_e      rd_owner_reg, rd_owner_next;
  logic        rd_oor_reg, rd_oor_next;
  logic        addr_err_reg;
  logic [31:0] cpu_rdata_reg;
  logic [31:0] dbg_rdata_reg;

  logic        starved;
  logic        cpu_gnt, dbg_gnt_int, any_gnt;
  logic        cpu_oor, dbg_oor, sel_oor;
  logic [3:0]  sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] ret_data;

  // Byte-offset bits never reach the word-addressed BRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], dbg_addr[1:0], sel_addr[1:0], sel_addr[31:ADDR_W+2]};

  // Anything above the BRAM word range is out of range.
  assign cpu_oor = |cpu_addr[31:ADDR_W+2];
  assign dbg_oor = |dbg_addr[31:ADDR_W+2];

  // Arbitration: lock > starvation > CPU priority; nothing granted in reset.
  always_comb begin
    starved     = (wait_cnt_reg == MAX_WAIT_C);
    cpu_gnt     = 1'b0;
    dbg_gnt_int = 1'b0;
    if (async_reset_n) begin
      if (dbg_lock) begin
        dbg_gnt_int = dbg_req;
      end else if (dbg_req && (!cpu_req || starved)) begin
        dbg_gnt_int = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
      end
    end
  end

  // BRAM-side mux from the granted requester; out-of-range writes are dropped.
  always_comb begin
    any_gnt   = cpu_gnt | dbg_gnt_int;
    sel_we    = dbg_gnt_int ? dbg_we    : cpu_we;
    sel_addr  = dbg_gnt_int ? dbg_addr  : cpu_addr;
    sel_wdata = dbg_gnt_int ? dbg_wdata : cpu_wdata;
    sel_oor   = dbg_gnt_int ? dbg_oor   : cpu_oor;
    mem_en    = any_gnt;
    mem_we    = (any_gnt && !sel_oor) ? sel_we : 4'h0;
    mem_addr  = sel_addr[ADDR_W+1:2];
    mem_wdata = sel_wdata;
    cpu_stall = cpu_req & ~cpu_gnt;
    dbg_gnt   = dbg_gnt_int;
  end

  // Next-state: starvation counter and read-return bookkeeping.
  always_comb begin
    wait_cnt_next = 4'd0;
    rd_owner_next = OWN_NONE;
    rd_oor_next   = 1'b0;
    if (dbg_req && !dbg_gnt_int) begin
      wait_cnt_next = starved ? wait_cnt_reg : wait_cnt_reg + 4'd1;
    end
    if (dbg_gnt_int && (dbg_we == 4'h0)) begin
      rd_owner_next = OWN_DBG;
    end else if (cpu_gnt && (cpu_we == 4'h0)) begin
      rd_owner_next = OWN_CPU;
    end
    rd_oor_next = any_gnt & sel_oor;
  end

  // State registers; a reset discards any pending read return.
  always_ff @(posedge clk_core or negedge async_reset_n) begin
    if (!async_reset_n) begin
      wait_cnt_reg  <= 4'd0;
      rd_owner_reg  <= OWN_NONE;
      rd_oor_reg    <= 1'b0;
      addr_err_reg  <= 1'b0;
      cpu_rdata_reg <= 32'h0;
      dbg_rdata_reg <= 32'h0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rd_owner_reg <= rd_owner_next;
      rd_oor_reg   <= rd_oor_next;
      addr_err_reg <= addr_err_reg | rd_oor_next;
      if (rd_owner_reg == OWN_CPU) cpu_rdata_reg <= ret_data;
      if (rd_owner_reg == OWN_DBG) dbg_rdata_reg <= ret_data;
    end
  end

  // Return path: live BRAM data for the owner, held value otherwise.
  always_comb begin
    ret_data   = rd_oor_reg ? 32'h0 : mem_rdata;
    dbg_rvalid = (rd_owner_reg == OWN_DBG);
    cpu_rdata  = (rd_owner_reg == OWN_CPU) ? ret_data : cpu_rdata_reg;
    dbg_rdata  = dbg_rvalid ? ret_data : dbg_rdata_reg;
    addr_err   = addr_err_reg;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a behavioural BRAM answers the
// arbiter, expected read returns are queued when an access is driven and
// popped one cycle later when the data must appear.
module tb_dmem_port_arbiter;

  localparam int TB_ADDR_W   = 10;
  localparam int TB_MAX_WAIT = 4;
  localparam logic [1:0] K_CPU = 2'd1;
  localparam logic [1:0] K_DBG = 2'd2;

  logic                 clk_core;
  logic                 async_reset_n;
  logic                 cpu_req;
  logic [3:0]           cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic                 cpu_stall;
  logic [31:0]          cpu_rdata;
  logic                 dbg_req;
  logic [3:0]           dbg_we;
  logic [31:0]          dbg_addr;
  logic [31:0]          dbg_wdata;
  logic                 dbg_lock;
  logic                 dbg_gnt;
  logic                 dbg_rvalid;
  logic [31:0]          dbg_rdata;
  logic                 addr_err;
  logic                 mem_en;
  logic [3:0]           mem_we;
  logic [TB_ADDR_W-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } ret_t;

  ret_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural BRAM with preload port
  logic [31:0]          bram [0:(1<<TB_ADDR_W)-1];
  logic                 pl_en;
  logic [TB_ADDR_W-1:0] pl_addr;
  logic [31:0]          pl_data;

  dmem_port_arbiter #(.ADDR_W(TB_ADDR_W), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk_core      (clk_core),
    .async_reset_n (async_reset_n),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_stall     (cpu_stall),
    .cpu_rdata     (cpu_rdata),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_lock      (dbg_lock),
    .dbg_gnt       (dbg_gnt),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .addr_err      (addr_err),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) begin
    if (pl_en) begin
      bram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_ret(input logic [1:0] k, input logic [31:0] d);
    ret_t r;
    r.kind = k;
    r.data = d;
    sb.push_back(r);
    $display("txn t=%0t %s read expect %h", $time, (k == K_CPU) ? "cpu" : "dbg", d);
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 4'h0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    dbg_lock = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  // Advance one clock and check the read return owed for the previous cycle.
  task automatic step();
    ret_t r;
    @(posedge clk_core);
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (r.kind == K_CPU) begin
        check_eq("cpu_rdata", cpu_rdata, r.data);
        check_eq("dbg_rvalid_cpu_ret", {31'h0, dbg_rvalid}, 32'h0);
      end else begin
        check_eq("dbg_rvalid", {31'h0, dbg_rvalid}, 32'h1);
        check_eq("dbg_rdata", dbg_rdata, r.data);
      end
    end else begin
      check_eq("dbg_rvalid_idle", {31'h0, dbg_rvalid}, 32'h0);
    end
  endtask

  // Both ports read continuously; debug must win every (MAX_WAIT+1)th cycle.
  task automatic run_contention(input int n, input string tag);
    logic exp_dbg;
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'hC; dbg_lock = 1'b0;
    for (int i = 0; i < n; i++) begin
      settle();
      exp_dbg = ((i % (TB_MAX_WAIT + 1)) == TB_MAX_WAIT);
      check_eq({tag, "_dbg_gnt"}, {31'h0, dbg_gnt}, {31'h0, exp_dbg});
      check_eq({tag, "_cpu_stall"}, {31'h0, cpu_stall}, {31'h0, exp_dbg});
      check_eq({tag, "_one_grant"}, 32'(int'(dbg_gnt) + int'(!cpu_stall)), 32'd1);
      check_eq({tag, "_mem_addr"}, 32'(mem_addr), exp_dbg ? 32'd3 : 32'd4);
      if (exp_dbg) push_ret(K_DBG, 32'h22222222);
      else         push_ret(K_CPU, 32'hDEADBEEF);
      step();
    end
  endtask

  initial begin
    logic [TB_ADDR_W-1:0] pa [4];
    logic [31:0]          pd [4];
    pa[0] = 10'd0; pd[0] = 32'hCAFEF00D;
    pa[1] = 10'd2; pd[1] = 32'h11111111;
    pa[2] = 10'd3; pd[2] = 32'h22222222;
    pa[3] = 10'd4; pd[3] = 32'hDEADBEEF;

    drive_idle();
    async_reset_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
    @(posedge clk_core); #1;
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_addr = pa[i]; pl_data = pd[i];
      @(posedge clk_core); #1;
    end
    pl_en = 1'b0;

    // Reset state: requests present but nothing granted
    cpu_req = 1'b1; dbg_req = 1'b1;
    settle();
    check_eq("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check_eq("rst_mem_we", {28'h0, mem_we}, 32'h0);
    check_eq("rst_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
    check_eq("rst_cpu_stall", {31'h0, cpu_stall}, 32'h1);
    check_eq("rst_dbg_rvalid", {31'h0, dbg_rvalid}, 32'h0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst_dbg_rdata", dbg_rdata, 32'h0);
    check_eq("rst_addr_err", {31'h0, addr_err}, 32'h0);
    @(posedge clk_core); #1;
    drive_idle();
    async_reset_n = 1'b1;

    // CPU-only read of word 4
    cpu_req = 1'b1; cpu_addr = 32'h10;
    settle();
    check_eq("cpu_rd_mem_en", {31'h0, mem_en}, 32'h1);
    check_eq("cpu_rd_mem_addr", 32'(mem_addr), 32'd4);
    check_eq("cpu_rd_stall", {31'h0, cpu_stall}, 32'h0);
    push_ret(K_CPU, 32'hDEADBEEF);
    step();

    // Alternating owners: CPU word 2 then debug word 3
    drive_idle(); cpu_req = 1'b1; cpu_addr = 32'h8;
    settle();
    check_eq("alt_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    push_ret(K_CPU, 32'h11111111);
    step();
    drive_idle(); dbg_req = 1'b1; dbg_addr = 32'hC;
    settle();
    check_eq("alt_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
    check_eq("alt_dbg_mem_addr", 32'(mem_addr), 32'd3);
    push_ret(K_DBG, 32'h22222222);
    step();
    drive_idle();
    step();
    step();
    check_eq("hold_cpu_rdata", cpu_rdata, 32'h11111111);
    check_eq("hold_dbg_rdata", dbg_rdata, 32'h22222222);

    // Starvation counter under continuous contention
    run_contention(10, "starve");
    drive_idle();
    step();

    // In-flight CPU read survives a lock asserted the next cycle
    cpu_req = 1'b1; cpu_addr = 32'h10;
    settle();
    push_ret(K_CPU, 32'hDEADBEEF);
    step();
    cpu_addr = 32'h8;
    dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h8; dbg_wdata = 32'hA5A5A5A5;
    settle();
    check_eq("lock_cpu_stall", {31'h0, cpu_stall}, 32'h1);
    check_eq("lock_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
    check_eq("lock_mem_we", {28'h0, mem_we}, 32'hF);
    check_eq("lock_mem_addr", 32'(mem_addr), 32'd2);
    check_eq("lock_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    $display("txn t=%0t dbg write word 2 = a5a5a5a5 under lock", $time);
    step();
    dbg_req = 1'b0; dbg_we = 4'h0;
    settle();
    check_eq("lock_idle_stall", {31'h0, cpu_stall}, 32'h1);
    check_eq("lock_idle_mem_en", {31'h0, mem_en}, 32'h0);
    step();
    dbg_lock = 1'b0;
    settle();
    check_eq("unlock_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    check_eq("unlock_mem_addr", 32'(mem_addr), 32'd2);
    push_ret(K_CPU, 32'hA5A5A5A5);
    step();
    drive_idle();

    // Out-of-range debug write and read
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h1000; dbg_wdata = 32'h12345678;
    settle();
    check_eq("oor_wr_gnt", {31'h0, dbg_gnt}, 32'h1);
    check_eq("oor_wr_mem_we", {28'h0, mem_we}, 32'h0);
    check_eq("oor_err_before", {31'h0, addr_err}, 32'h0);
    $display("txn t=%0t dbg write 0x1000 out of range", $time);
    step();
    check_eq("oor_err_set", {31'h0, addr_err}, 32'h1);
    dbg_we = 4'h0;
    settle();
    check_eq("oor_rd_gnt", {31'h0, dbg_gnt}, 32'h1);
    push_ret(K_DBG, 32'h0);
    step();
    drive_idle(); cpu_req = 1'b1; cpu_addr = 32'h0;
    settle();
    push_ret(K_CPU, 32'hCAFEF00D);
    step();
    check_eq("oor_err_sticky", {31'h0, addr_err}, 32'h1);
    drive_idle();

    // Reset with the starvation counter part-way up
    cpu_req = 1'b1; cpu_addr = 32'h10; dbg_req = 1'b1; dbg_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("pre_rst_stall", {31'h0, cpu_stall}, 32'h0);
      push_ret(K_CPU, 32'hDEADBEEF);
      step();
    end
    async_reset_n = 1'b0;
    drive_idle();
    sb.delete();
    settle();
    check_eq("rst2_addr_err", {31'h0, addr_err}, 32'h0);
    check_eq("rst2_cpu_rdata", cpu_rdata, 32'h0);
    check_eq("rst2_mem_en", {31'h0, mem_en}, 32'h0);
    step();
    async_reset_n = 1'b1;
    run_contention(5, "post_rst");
    drive_idle();
    step();

    // Reset the cycle after a debug read grant discards the return
    dbg_req = 1'b1; dbg_addr = 32'hC;
    settle();
    check_eq("rst3_pre_gnt", {31'h0, dbg_gnt}, 32'h1);
    @(posedge clk_core); #1;
    async_reset_n = 1'b0;
    drive_idle();
    settle();
    check_eq("rst3_rvalid", {31'h0, dbg_rvalid}, 32'h0);
    check_eq("rst3_dbg_rdata", dbg_rdata, 32'h0);
    check_eq("rst3_addr_err", {31'h0, addr_err}, 32'h0);
    step();
    async_reset_n = 1'b1;
    step();
    dbg_req = 1'b1; dbg_addr = 32'hC;
    settle();
    check_eq("rst3_post_gnt", {31'h0, dbg_gnt}, 32'h1);
    push_ret(K_DBG, 32'h22222222);
    step();
    drive_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data BRAM between two requesters: the processor core's load/store port and a debug/loader port (UART loader, test DMA).
- Sits between the core/debug logic and the DATA_MEM BRAM, in the clk_core domain.
- Cycle-by-cycle arbitration:
  - CPU has default priority.
  - A starvation counter guarantees the debug port a slot.
  - A lock input gives the debug port exclusive ownership while the CPU is stalled.
- Routes the BRAM's 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 10, BRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- MAX_WAIT, 4, max consecutive cycles a pending debug request may lose to the CPU (1..15).

Ports:
- clk_core  in  1  core clock
- async_reset_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  4  CPU byte write enables; 0 = read
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_stall  out  1  CPU request not accepted this cycle; hold request
- cpu_rdata  out  32  CPU read data, valid cycle after accepted read
- dbg_req  in  1  debug access request
- dbg_we  in  4  debug byte write enables; 0 = read
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug write data
- dbg_lock  in  1  debug exclusive ownership; CPU fully stalled
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- addr_err  out  1  sticky: out-of-range access seen; cleared by reset only
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, 1-cycle latency

Behaviour:
- Grant (combinational, one access per cycle):
  - dbg_lock=1: CPU never granted. Debug is granted whenever dbg_req=1.
  - dbg_lock=0, both requesting: CPU wins unless wait_cnt == MAX_WAIT, in which case debug wins.
  - Single requester: that requester wins.
- cpu_stall = cpu_req & ~cpu_gnt.
- dbg_gnt = debug granted. The requester must hold req/we/addr/wdata stable until accepted.
- wait_cnt (4-bit register):
  - Increments when dbg_req=1 and debug is not granted.
  - Clears to 0 when debug is granted or dbg_req=0.
  - Saturates at MAX_WAIT.
- BRAM side:
  - mem_en = any grant.
  - mem_addr, mem_wdata, mem_we taken from the granted requester. Combinational muxing, no added latency.
- Range check:
  - An access is out-of-range if address bits [31:ADDR_W+2] ≠ 0.
  - An out-of-range access is still granted (handshake completes), but mem_we is forced to 0 and the read returns 0.
  - addr_err is set the cycle after the out-of-range grant.
- Read return:
  - Registers rd_owner {NONE, CPU, DBG} and rd_oor capture the owner and range status of the granted read.
  - Next cycle, if owner=DBG: dbg_rvalid=1 and dbg_rdata = rd_oor ? 0 : mem_rdata.
  - If owner=CPU: cpu_rdata = rd_oor ? 0 : mem_rdata.
  - Otherwise dbg_rvalid=0 and dbg_rdata holds its last value.
  - cpu_rdata is mem_rdata-gated only when owner=CPU; otherwise it holds the last value.
- Writes produce no read return; rd_owner=NONE.
- Back-to-back accesses from alternating owners are legal; each read's data is routed by its own rd_owner.
- Reset (async assert, sync release):
  - wait_cnt=0, rd_owner=NONE, rd_oor=0, addr_err=0, dbg_rvalid=0, dbg_rdata=0, cpu_rdata=0.
  - While in reset, all grants are forced 0: mem_en=0, mem_we=0, dbg_gnt=0, cpu_stall=cpu_req.
- Reset mid-read: the pending return is discarded (no dbg_rvalid after release).
- dbg_lock asserted mid-stream: takes effect the same cycle. An in-flight CPU read issued the previous cycle still returns to the CPU.

Test Plan:
- CPU only, read 0x0000_0010 with BRAM word 4 = 0xDEADBEEF → mem_en=1, mem_addr=4, no stall; cpu_rdata=0xDEADBEEF next cycle.
- Both requesting continuously, MAX_WAIT=4 → CPU granted 4 cycles, debug granted on the 5th (cpu_stall=1 that cycle); pattern repeats every 5 cycles; no lost or duplicated grants.
- Alternating reads: CPU read word 2 (0x11111111), then debug read word 3 (0x22222222) → cpu_rdata=0x11111111 at cycle+1; dbg_rvalid=1 with dbg_rdata=0x22222222 at cycle+2.
- dbg_lock=1 with cpu_req held: debug write we=0xF, addr 0x8, data 0xA5A5A5A5 → cpu_stall=1 throughout; mem_we=0xF, mem_addr=2; releasing lock lets the CPU be granted the next cycle.
- Debug write to 0x0000_1000 (ADDR_W=10) → dbg_gnt=1, mem_we=0, addr_err=1 next cycle and remains set; debug read of the same address → dbg_rdata=0.
- Assert async_reset_n low the cycle after a debug read grant → dbg_rvalid stays 0, wait_cnt=0, addr_err=0; after release the first request is granted normally.
